// File: rtl/hilo_pkg.sv
// Shared types and defaults for the HI/LO multiply sequencer.
// Used by hilo_ctrl and hilo_regs.
package hilo_pkg;

  localparam int HILO_TIMEOUT_DEFAULT = 40;
  localparam int HILO_GUARD_DEFAULT   = 2;
  localparam int HILO_CNT_W           = 6;

  typedef logic [HILO_CNT_W-1:0] hilo_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } hilo_state_e;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO registers: product capture plus optional mthi/mtlo
// write port (present only when HILO_MTHILO_EN is defined).
module hilo_regs
  import hilo_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        capture,
  input  logic [31:0] cap_hi,
  input  logic [31:0] cap_lo,
`ifdef HILO_MTHILO_EN
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wr_data,
`endif
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Capture and register writes are mutually exclusive by construction
  // (capture only in RUN, writes only in IDLE), so priority is immaterial.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (capture) begin
      hi_d = cap_hi;
      lo_d = cap_lo;
    end
`ifdef HILO_MTHILO_EN
    else begin
      if (hi_we) hi_d = wr_data;
      if (lo_we) lo_d = wr_data;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: rtl/hilo_ctrl.sv
// Multiply sequencer (IDLE/RUN/HOLD) driving the Booth multiplier enable and
// capturing its product into HI/LO. Optional mthi/mtlo port: HILO_MTHILO_EN.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = HILO_TIMEOUT_DEFAULT,
  parameter int GUARD_CYCLES   = HILO_GUARD_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Start,
  input  logic        MultDone,
  input  logic [31:0] MultHIOut,
  input  logic [31:0] MultLOOut,
`ifdef HILO_MTHILO_EN
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic [31:0] WriteData,
`endif
  output logic        MultCtrl,
  output logic        Busy,
  output logic        Done,
  output logic        Timeout,
  output logic [31:0] HIOut,
  output logic [31:0] LOOut
);

  localparam hilo_cnt_t GUARD_C   = hilo_cnt_t'(GUARD_CYCLES);
  localparam hilo_cnt_t TIMEOUT_C = hilo_cnt_t'(TIMEOUT_CYCLES);
  localparam hilo_cnt_t CNT_MAX   = '1;

  hilo_state_e state_q, state_d;
  hilo_cnt_t   cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        valid_done;
  logic        timeout_hit;

  // A MultDone still high from the previous operation is only cleared by the
  // multiplier's init cycle, so it is ignored for the first GUARD_CYCLES.
  assign valid_done  = (state_q == ST_RUN) && MultDone && (cnt_q >= GUARD_C);
  assign timeout_hit = (state_q == ST_RUN) && !valid_done && (cnt_q >= TIMEOUT_C);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      ST_RUN: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + hilo_cnt_t'(1);
        if (valid_done) begin
          state_d = ST_HOLD;
        end else if (timeout_hit) begin
          state_d   = ST_HOLD;
          timeout_d = 1'b1;
        end
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // HOLD is the one-cycle low gap on MultCtrl that re-arms the multiplier.
  assign MultCtrl = (state_q == ST_RUN);
  assign Busy     = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign Done     = (state_q == ST_HOLD) && !timeout_q;
  assign Timeout  = timeout_q;

`ifdef HILO_MTHILO_EN
  logic hi_we;
  logic lo_we;
  assign hi_we = HIWrite && (state_q == ST_IDLE);
  assign lo_we = LOWrite && (state_q == ST_IDLE);
`endif

  hilo_regs u_regs (
    .clock   (clock),
    .reset   (reset),
    .capture (valid_done),
    .cap_hi  (MultHIOut),
    .cap_lo  (MultLOOut),
`ifdef HILO_MTHILO_EN
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wr_data (WriteData),
`endif
    .hi_out  (HIOut),
    .lo_out  (LOOut)
  );

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with a behavioural 32-cycle multiplier model
// and a stub mode for driving MultDone directly.
module tb_hilo_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        Start;
  logic        MultDone;
  logic [31:0] MultHIOut;
  logic [31:0] MultLOOut;
  logic        MultCtrl;
  logic        Busy;
  logic        Done;
  logic        Timeout;
  logic [31:0] HIOut;
  logic [31:0] LOOut;
`ifdef HILO_MTHILO_EN
  logic        HIWrite = 1'b0;
  logic        LOWrite = 1'b0;
  logic [31:0] WriteData = '0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hilo_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .Start     (Start),
    .MultDone  (MultDone),
    .MultHIOut (MultHIOut),
    .MultLOOut (MultLOOut),
`ifdef HILO_MTHILO_EN
    .HIWrite   (HIWrite),
    .LOWrite   (LOWrite),
    .WriteData (WriteData),
`endif
    .MultCtrl  (MultCtrl),
    .Busy      (Busy),
    .Done      (Done),
    .Timeout   (Timeout),
    .HIOut     (HIOut),
    .LOOut     (LOOut)
  );

  // Multiplier model: init on first enabled edge, 32 iterations, done after.
  logic [31:0] op_a = '0, op_b = '0;
  logic [63:0] m_prod;
  logic        m_run = 1'b0;
  logic [5:0]  m_cnt = '0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        stub_mode = 1'b0;
  logic        stub_done = 1'b0;
  logic [31:0] stub_hi = '0, stub_lo = '0;

  assign m_prod    = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
  assign MultDone  = stub_mode ? stub_done : m_done;
  assign MultHIOut = stub_mode ? stub_hi : m_hi;
  assign MultLOOut = stub_mode ? stub_lo : m_lo;

  always @(posedge clock) begin
    if (!MultCtrl) begin
      m_run <= 1'b0;
    end else if (!m_run) begin
      m_run  <= 1'b1;
      m_cnt  <= '0;
      m_done <= 1'b0;
    end else if (m_cnt < 6'd32) begin
      m_cnt <= m_cnt + 6'd1;
    end else if (m_cnt == 6'd32) begin
      m_cnt  <= 6'd33;
      m_done <= 1'b1;
      m_hi   <= m_prod[63:32];
      m_lo   <= m_prod[31:0];
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Leaves the bench just after edge 0 of the new operation.
  task automatic do_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0;
    tick(); tick();
    checks++; if (MultCtrl !== 1'b0) begin errors++; $display("FAIL reset_multctrl got=%b exp=0", MultCtrl); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", Done); end
    checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", Timeout); end
    checks++; if (HIOut !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", HIOut); end
    checks++; if (LOOut !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", LOOut); end
    reset = 1'b0;
    tick();
  endtask

  // Full model-backed multiply; returns just after edge 36 (IDLE again).
  task automatic test_multiply(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    stub_mode = 1'b0;
    op_a = a; op_b = b;
    do_start();
    checks++; if (MultCtrl !== 1'b1) begin errors++; $display("FAIL mul_multctrl_e0 got=%b exp=1", MultCtrl); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL mul_busy_e0 got=%b exp=1", Busy); end
    repeat (34) tick();
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL mul_done_e34 got=%b exp=0", Done); end
    tick();
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL mul_done_e35 got=%b exp=1", Done); end
    checks++; if (HIOut !== exp_hi) begin errors++; $display("FAIL mul_hi got=%h exp=%h", HIOut, exp_hi); end
    checks++; if (LOOut !== exp_lo) begin errors++; $display("FAIL mul_lo got=%h exp=%h", LOOut, exp_lo); end
    checks++; if (MultCtrl !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL mul_hold got multctrl=%b busy=%b exp 0/1", MultCtrl, Busy); end
    tick();
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL mul_idle got busy=%b done=%b exp 0/0", Busy, Done); end
    $display("mul A=%h B=%h -> HI=%h LO=%h", a, b, HIOut, LOOut);
  endtask

  task automatic test_guard();
    stub_mode = 1'b1; stub_done = 1'b1;
    stub_hi = 32'hDEADDEAD; stub_lo = 32'hBEEFBEEF;
    tick();
    do_start();
    tick();
    checks++; if (Done !== 1'b0 || MultCtrl !== 1'b1) begin errors++; $display("FAIL guard_e1 got done=%b multctrl=%b exp 0/1", Done, MultCtrl); end
    tick();
    checks++; if (Done !== 1'b0 || MultCtrl !== 1'b1) begin errors++; $display("FAIL guard_e2 got done=%b multctrl=%b exp 0/1", Done, MultCtrl); end
    checks++; if (HIOut !== 32'h40000000) begin errors++; $display("FAIL guard_hi_kept got=%h exp=40000000", HIOut); end
    stub_done = 1'b0;
    repeat (32) tick();
    stub_done = 1'b1; stub_hi = 32'h00000001; stub_lo = 32'h23456789;
    checks++; if (Done !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL guard_e34 got done=%b busy=%b exp 0/1", Done, Busy); end
    tick();
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL guard_done_e35 got=%b exp=1", Done); end
    checks++; if (HIOut !== 32'h00000001 || LOOut !== 32'h23456789) begin errors++; $display("FAIL guard_capture got=%h_%h exp=00000001_23456789", HIOut, LOOut); end
    tick();
    stub_done = 1'b0;
    $display("guard capture HI=%h LO=%h", HIOut, LOOut);
  endtask

  task automatic test_timeout();
    stub_mode = 1'b1; stub_done = 1'b0;
    do_start();
    repeat (40) tick();
    checks++; if (Timeout !== 1'b0 || MultCtrl !== 1'b1) begin errors++; $display("FAIL to_e40 got timeout=%b multctrl=%b exp 0/1", Timeout, MultCtrl); end
    tick();
    checks++; if (Timeout !== 1'b1) begin errors++; $display("FAIL to_flag_e41 got=%b exp=1", Timeout); end
    checks++; if (Done !== 1'b0 || MultCtrl !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL to_hold got done=%b multctrl=%b busy=%b exp 0/0/1", Done, MultCtrl, Busy); end
    checks++; if (HIOut !== 32'h00000001 || LOOut !== 32'h23456789) begin errors++; $display("FAIL to_retain got=%h_%h exp=00000001_23456789", HIOut, LOOut); end
    tick();
    checks++; if (Busy !== 1'b0 || Timeout !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL to_e42 got busy=%b timeout=%b done=%b exp 0/1/0", Busy, Timeout, Done); end
    tick();
    checks++; if (Timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", Timeout); end
    stub_mode = 1'b0; op_a = 32'd6; op_b = 32'd7;
    do_start();
    checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL to_clear_on_start got=%b exp=0", Timeout); end
    repeat (35) tick();
    checks++; if (Done !== 1'b1 || LOOut !== 32'd42 || HIOut !== 32'h0) begin errors++; $display("FAIL to_next_op got done=%b hi=%h lo=%h exp 1/0/2a", Done, HIOut, LOOut); end
    tick();
    $display("timeout then recover HI=%h LO=%h", HIOut, LOOut);
  endtask

  task automatic test_reset_mid_run();
    stub_mode = 1'b0; op_a = 32'd9; op_b = 32'd9;
    do_start();
    repeat (10) tick();
    reset = 1'b1;
    tick();
    checks++; if (MultCtrl !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got multctrl=%b busy=%b done=%b exp 0/0/0", MultCtrl, Busy, Done); end
    checks++; if (HIOut !== 32'h0 || LOOut !== 32'h0 || Timeout !== 1'b0) begin errors++; $display("FAIL midrst_regs got hi=%h lo=%h timeout=%b exp 0/0/0", HIOut, LOOut, Timeout); end
    reset = 1'b0;
    tick();
    test_multiply(32'd7, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2);
  endtask

  task automatic test_ignored_start();
    stub_mode = 1'b1; stub_done = 1'b0;
    do_start();
    repeat (40) tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL start_in_hold_not_queued got busy=%b exp=0", Busy); end
    stub_mode = 1'b0;
    tick();
  endtask

`ifdef HILO_MTHILO_EN
  task automatic test_mthilo();
    HIWrite = 1'b1; WriteData = 32'h12345678;
    tick();
    HIWrite = 1'b0;
    checks++; if (HIOut !== 32'h12345678) begin errors++; $display("FAIL mthi got=%h exp=12345678", HIOut); end
    op_a = 32'd3; op_b = 32'd5;
    do_start();
    tick();
    LOWrite = 1'b1; WriteData = 32'hAAAA5555;
    tick();
    LOWrite = 1'b0;
    checks++; if (LOOut === 32'hAAAA5555) begin errors++; $display("FAIL mtlo_in_run got=%h exp=not aaaa5555", LOOut); end
    repeat (33) tick();
    checks++; if (LOOut !== 32'h0000000F) begin errors++; $display("FAIL mtlo_product got=%h exp=0000000f", LOOut); end
    tick();
  endtask
`endif

  initial begin
    reset = 1'b0; Start = 1'b0;
    @(negedge clock);
    test_reset();
    test_multiply(32'd3, 32'd5, 32'h00000000, 32'h0000000F);
    tick();
    test_multiply(32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    test_multiply(32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    tick();
    test_guard();
    test_timeout();
    test_reset_mid_run();
    test_ignored_start();
`ifdef HILO_MTHILO_EN
    test_mthilo();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
